wb_arbiter_2m: RTL and testbench
================================

Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone B3 arbiter that shares a single slave port (the system SRAM) between the CPU instruction master (m0) and data master (m1).
- Sits between the CPU wrapper and the RAM slave port, ahead of the bus matrix decode.
- Round-robin fairness, with grant locked for a whole cycle (CYC).
- Bus watchdog that terminates a hung transfer with an error.

Parameters:
- AW, 32, address width.
- DW, 32, data width; select width is DW/8.
- TIMEOUT, 255, cycles of unanswered STB before a forced error; 0 disables the watchdog.
- TW, 8, watchdog counter width; TIMEOUT must be < 2**TW.

Ports:
- clk_i  in  1  system clock
- nrst_i  in  1  asynchronous reset, active low
- mN_adr_i  in  AW  master N address (N = 0, 1; every mN_* port exists for both masters)
- mN_dat_i  in  DW  master N write data
- mN_sel_i  in  DW/8  master N byte select
- mN_we_i  in  1  master N write enable
- mN_cti_i  in  3  master N cycle type
- mN_bte_i  in  2  master N burst type
- mN_cyc_i  in  1  master N cycle
- mN_stb_i  in  1  master N strobe
- mN_dat_o  out  DW  read data to master N
- mN_ack_o  out  1  acknowledge to master N
- mN_err_o  out  1  error to master N
- mN_rty_o  out  1  retry to master N
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o  out  AW, DW, DW/8, 1, 3, 2, 1, 1  slave request
- s_dat_i, s_ack_i, s_err_i, s_rty_i  in  DW, 1, 1, 1  slave response
- grant_o  out  2  one-hot current grant (bit0 = m0)
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
Reset (nrst_i low, asynchronous):
- state = IDLE, grant_o = 2'b00, last = 1 (so m0 wins first), watchdog = 0, timeout_o = 0.
- All slave outputs are 0; all master outputs are 0.

FSM states: IDLE, G0, G1; state is registered.
- IDLE, only m0_cyc_i high -> G0. Only m1_cyc_i high -> G1.
- IDLE, both high -> the master not equal to last. Neither high -> stay in IDLE.
- Gn: stay while mn_cyc_i is high. When mn_cyc_i is low -> IDLE, and last = n.
- Re-arbitration always passes through IDLE, costing one bubble cycle between cycles. A master that holds CYC is never preempted.
- Grant latency: request seen in IDLE at edge k; slave sees the request from cycle k+1.

Muxing (combinational from state):
- In Gn, all s_* request outputs = mn_* inputs.
- mn_dat_o = s_dat_i; mn_ack_o = s_ack_i; mn_err_o = s_err_i | wd_fire; mn_rty_o = s_rty_i.
- The non-granted master sees ack/err/rty = 0 and dat = 0.
- In IDLE, s_cyc_o = s_stb_o = 0; other s_* outputs are 0.

Watchdog (TIMEOUT != 0):
- Counts up each cycle in Gn with s_stb_o = 1 and no ack/err/rty from the slave.
- Clears on any slave response, when stb is low, or on state change.
- wd_fire = count == TIMEOUT-1 and no slave response in that cycle. On wd_fire:
  - one-cycle err to the granted master;
  - s_stb_o is forced low that cycle;
  - timeout_o pulses (registered, so it appears one cycle after err);
  - counter clears.
- The grant is kept; the master is expected to drop CYC.

Simultaneous events and boundaries:
- Slave ack in the same cycle the watchdog would fire: the ack wins, no err is generated.
- The granted master drops CYC in the same cycle the other raises CYC: go to IDLE, then grant the other master.
- Reset asserted mid-transfer: immediate IDLE; slave cyc/stb drop asynchronously.
- Counter saturation cannot occur because TIMEOUT < 2**TW.

Test Plan:
- Reset then idle: nrst_i low for 3 cycles, then m0_cyc=m1_cyc=0 -> grant_o=00, s_cyc_o=0, all master ack/err/rty=0.
- Single master: m1 read at adr 0x0000_0010, slave acks 2 cycles after stb with dat 0xDEAD_BEEF -> grant_o=10 one cycle after the request, m1_dat_o=0xDEAD_BEEF with m1_ack_o, m0_ack_o stays 0.
- Contention round robin: both request continuously, each performing 1 transfer and dropping CYC -> grant sequence m0, IDLE, m1, IDLE, m0, IDLE, m1.
- Lock: m0 holds CYC over a 4-beat burst (cti=010, then 111) while m1 requests -> m1 is never granted until m0_cyc falls; then grant_o=10 two cycles later.
- Watchdog: TIMEOUT=8, slave never responds to m0 stb -> m0_err_o high in cycle 8 of stb, s_stb_o low that cycle, timeout_o pulses next cycle. Repeat with ack arriving exactly in cycle 8 -> ack only, no err, no timeout_o.
- Async reset mid-transfer: drop nrst_i while G1 with stb high -> s_cyc_o/s_stb_o go to 0 without a clock edge. After release, with both masters requesting, m0 is granted first.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master / one-slave Wishbone B3 arbiter, round-robin, grant locked for a whole CYC, with bus watchdog.
// Latency: a request seen in IDLE at edge k reaches the slave from cycle k+1; one bubble cycle between grants.
// Backpressure: the granted master owns the slave while it holds CYC; the other master waits with CYC high.
//
// Ports:
//   clk_i, nrst_i                     clock, asynchronous active-low reset
//   m0_*_i / m1_*_i                   Wishbone master requests (adr, dat, sel, we, cti, bte, cyc, stb)
//   m0_*_o / m1_*_o                   responses to each master (dat, ack, err, rty)
//   s_*_o / s_*_i                     shared slave request / response
//   grant_o                           one-hot current grant (bit0 = m0)
//   timeout_o                         one-cycle pulse, registered, one cycle after a watchdog error
module wb_arbiter_2m #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW-1:0]     m0_dat_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  input  logic              m0_we_i,
  input  logic [2:0]        m0_cti_i,
  input  logic [1:0]        m0_bte_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  output logic [DW-1:0]     m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic              m0_rty_o,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic              m1_we_i,
  input  logic [2:0]        m1_cti_i,
  input  logic [1:0]        m1_bte_i,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  output logic [DW-1:0]     m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              m1_rty_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic              s_we_o,
  output logic [2:0]        s_cti_o,
  output logic [1:0]        s_bte_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_rty_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

  // Counter value in the last unanswered strobe cycle before the forced error.
  localparam logic [TW-1:0] WD_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_last;      // master whose cycle ended most recently (1 = m1)
  logic [TW-1:0] r_wd_cnt;
  logic          r_timeout;
  logic          w_resp;
  logic          w_stb_req;
  logic          w_wd_fire;

  assign w_resp    = s_ack_i | s_err_i | s_rty_i;
  assign w_stb_req = ((r_state == ST_G0) && m0_stb_i) || ((r_state == ST_G1) && m1_stb_i);
  // A slave response in the firing cycle takes priority over the watchdog.
  assign w_wd_fire = (TIMEOUT != 0) && w_stb_req && !w_resp && (r_wd_cnt == WD_LAST);

  // State register.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: every re-arbitration passes through IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_state_nxt = r_last ? ST_G0 : ST_G1;
        end else if (m0_cyc_i) begin
          w_state_nxt = ST_G0;
        end else if (m1_cyc_i) begin
          w_state_nxt = ST_G1;
        end
      end
      ST_G0:   if (!m0_cyc_i) w_state_nxt = ST_IDLE;
      ST_G1:   if (!m1_cyc_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Round-robin history, updated when a granted cycle ends.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_last <= 1'b1;
    end else if ((r_state == ST_G0) && !m0_cyc_i) begin
      r_last <= 1'b0;
    end else if ((r_state == ST_G1) && !m1_cyc_i) begin
      r_last <= 1'b1;
    end
  end

  // Watchdog counter and registered timeout pulse.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_wd_fire;
      if (!w_stb_req || w_resp || w_wd_fire || (w_state_nxt != r_state)) begin
        r_wd_cnt <= '0;
      end else begin
        r_wd_cnt <= r_wd_cnt + TW'(1);
      end
    end
  end

  // Output muxing, purely from the registered state.
  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_cti_o   = '0;
    s_bte_o   = '0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    m0_dat_o  = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m0_rty_o  = 1'b0;
    m1_dat_o  = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    m1_rty_o  = 1'b0;
    grant_o   = 2'b00;
    timeout_o = r_timeout;
    case (r_state)
      ST_G0: begin
        grant_o  = 2'b01;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~w_wd_fire;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | w_wd_fire;
        m0_rty_o = s_rty_i;
      end
      ST_G1: begin
        grant_o  = 2'b10;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~w_wd_fire;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | w_wd_fire;
        m1_rty_o = s_rty_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: directed scenarios plus randomized two-master traffic against a rule-level arbiter model.
// Latency: inputs change 1 time unit after the rising edge, outputs are sampled 2-3 units after it.
// Backpressure: the bench slave answers with a random 0..3 cycle wait; masters hold CYC until acked.
module tb_wb_arbiter_2m;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
  logic [2:0]  m0_cti, m1_cti;
  logic [1:0]  m0_bte, m1_bte;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb, s_ack, s_err, s_rty;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [1:0]  grant;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT(8), .TW(8)) dut (
    .clk_i(clk), .nrst_i(nrst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_cti_i(m0_cti), .m0_bte_i(m0_bte), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
    .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_cti_i(m1_cti), .m1_bte_i(m1_bte), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
    .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_cti_o(s_cti), .s_bte_o(s_bte), .s_cyc_o(s_cyc), .s_stb_o(s_stb),
    .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant), .timeout_o(timeout)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = cyc; m0_we = we; m0_adr = adr; m0_dat = dat; m0_cti = cti;
      m0_sel = 4'hF; m0_bte = 2'b00;
    end else begin
      m1_cyc = cyc; m1_stb = cyc; m1_we = we; m1_adr = adr; m1_dat = dat; m1_cti = cti;
      m1_sel = 4'hF; m1_bte = 2'b00;
    end
  endtask

  task automatic idle_all();
    drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_rdat = 32'h0;
  endtask

  // ---------------- randomized traffic engine and reference model ----------------
  bit          busy [2];
  int          cool [2];
  int          left [2];
  logic [31:0] t_adr [2];
  logic [31:0] t_dat [2];
  bit          t_we  [2];
  logic [31:0] rmem [16];   // memory as each master believes it to be
  logic [31:0] smem [16];   // memory held by the bench slave
  int          swait, slat;
  bit          mdl_last;    // 1: m1's cycle ended most recently
  logic [1:0]  prev_g;
  bit          pcyc [2];
  logic [1:0]  glog [$];

  task automatic eng_init(input int n0, input int n1, input int max_lat);
    busy[0] = 0; busy[1] = 0; cool[0] = 0; cool[1] = 0;
    left[0] = n0; left[1] = n1;
    pcyc[0] = 0; pcyc[1] = 0; prev_g = 2'b00;
    swait = 0; slat = $urandom_range(0, max_lat);
    glog.delete();
  endtask

  task automatic engine(input int ncyc, input int max_cool, input int max_lat);
    logic [1:0] exp_g;
    logic [1:0] lastlog;
    lastlog = 2'b00;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        if (!busy[m]) begin
          if (cool[m] > 0) cool[m]--;
          else if (left[m] > 0) begin
            busy[m]  = 1;
            t_adr[m] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            t_dat[m] = $urandom;
            t_we[m]  = 1'($urandom_range(0, 1));
          end
        end
        if (busy[m]) drive_m(m, 1'b1, t_we[m], t_adr[m], t_dat[m], 3'b000);
        else         drive_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      end
      // Rule model: grant held while owner's CYC stays up, bubble after it drops,
      // from idle pick the sole requester or the one that was not served last.
      if (prev_g == 2'b01) begin
        exp_g = pcyc[0] ? 2'b01 : 2'b00;
        if (!pcyc[0]) mdl_last = 0;
      end else if (prev_g == 2'b10) begin
        exp_g = pcyc[1] ? 2'b10 : 2'b00;
        if (!pcyc[1]) mdl_last = 1;
      end else if (pcyc[0] && pcyc[1]) exp_g = mdl_last ? 2'b01 : 2'b10;
      else if (pcyc[0]) exp_g = 2'b01;
      else if (pcyc[1]) exp_g = 2'b10;
      else exp_g = 2'b00;
      pcyc[0] = busy[0]; pcyc[1] = busy[1];
      prev_g = exp_g;
      #1;
      s_ack = 1'b0; s_rdat = 32'h0;
      if (s_stb) begin
        if (swait >= slat) begin
          s_ack = 1'b1;
          if (s_we) smem[s_adr[5:2]] = s_wdat;
          else      s_rdat = smem[s_adr[5:2]];
        end else swait++;
      end
      #1;
      check("grant", 32'(grant), 32'(exp_g));
      check("timeout", 32'(timeout), 32'd0);
      if (exp_g == 2'b01) begin
        check("s_adr_m0", s_adr, m0_adr);
        check("s_cyc_m0", 32'(s_cyc), 32'(m0_cyc));
      end else if (exp_g == 2'b10) begin
        check("s_adr_m1", s_adr, m1_adr);
        check("s_cyc_m1", 32'(s_cyc), 32'(m1_cyc));
      end else begin
        check("s_cyc_idle", 32'({s_cyc, s_stb}), 32'd0);
      end
      check("ack0", 32'(m0_ack), 32'((exp_g == 2'b01) && s_ack));
      check("ack1", 32'(m1_ack), 32'((exp_g == 2'b10) && s_ack));
      for (int m = 0; m < 2; m++) begin
        if (s_ack && exp_g[m] && busy[m]) begin
          if (t_we[m]) rmem[t_adr[m][5:2]] = t_dat[m];
          else check(m == 0 ? "rdat0" : "rdat1", m == 0 ? m0_rdat : m1_rdat, rmem[t_adr[m][5:2]]);
          busy[m] = 0;
          cool[m] = 1 + $urandom_range(0, max_cool);
          left[m]--;
          swait = 0;
          slat  = $urandom_range(0, max_lat);
        end
      end
      if (grant != lastlog && (glog.size() != 0 || grant != 2'b00)) glog.push_back(grant);
      lastlog = grant;
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [1:0] rr_seq [7];
    rr_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    for (int i = 0; i < 16; i++) begin rmem[i] = 32'h0; smem[i] = 32'h0; end
    idle_all();

    // Reset and idle
    repeat (3) tick();
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_scyc", 32'({s_cyc, s_stb}), 32'd0);
    check("rst_mresp", 32'({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    tick();
    nrst = 1'b1;
    #1;
    check("idle_grant", 32'(grant), 32'd0);
    check("idle_scyc", 32'(s_cyc), 32'd0);

    // Single master m1 read, slave answers two cycles after the first strobe
    tick();
    drive_m(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 3'b000);
    #1 check("m1_req_cycle_grant", 32'(grant), 32'd0);
    tick();
    #1;
    check("m1_grant", 32'(grant), 32'b10);
    check("m1_s_adr", s_adr, 32'h0000_0010);
    check("m1_s_stb", 32'({s_cyc, s_stb}), 32'b11);
    check("m1_noack_w1", 32'(m1_ack), 32'd0);
    tick();
    #1 check("m1_noack_w2", 32'(m1_ack), 32'd0);
    tick();
    s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
    #1;
    check("m1_rdat", m1_rdat, 32'hDEAD_BEEF);
    check("m1_ack", 32'(m1_ack), 32'd1);
    check("m0_ack_quiet", 32'(m0_ack), 32'd0);
    check("m0_dat_quiet", m0_rdat, 32'h0);
    tick();
    idle_all();
    #1 check("m1_drop_grant", 32'(grant), 32'b10);
    tick();
    #1 check("m1_bubble", 32'(grant), 32'd0);

    // Contention: both request continuously, one transfer per cycle, zero-wait slave
    mdl_last = 1;
    eng_init(2, 2, 0);
    engine(14, 0, 0);
    for (int i = 0; i < 7; i++)
      check($sformatf("rr_seq%0d", i), (i < glog.size()) ? 32'(glog[i]) : 32'hFFFF, 32'(rr_seq[i]));
    idle_all();
    tick();
    tick();

    // Lock: m0 4-beat burst, m1 requesting throughout
    drive_m(0, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
    #1 check("lock_req_grant", 32'(grant), 32'd0);
    for (int b = 0; b < 4; b++) begin
      tick();
      drive_m(0, 1'b1, 1'b0, 32'h20 + 32'(b * 4), 32'h0, (b == 3) ? 3'b111 : 3'b010);
      drive_m(1, 1'b1, 1'b0, 32'h44, 32'h0, 3'b000);
      s_ack = 1'b1; s_rdat = 32'(b);
      #1;
      check($sformatf("lock_grant_b%0d", b), 32'(grant), 32'b01);
      check($sformatf("lock_cti_b%0d", b), 32'(s_cti), (b == 3) ? 32'b111 : 32'b010);
      check($sformatf("lock_m1ack_b%0d", b), 32'(m1_ack), 32'd0);
      check($sformatf("lock_m0ack_b%0d", b), 32'(m0_ack), 32'd1);
    end
    tick();
    drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    s_ack = 1'b0;
    #1 check("lock_drop_grant", 32'(grant), 32'b01);
    tick();
    #1 check("lock_bubble", 32'(grant), 32'd0);
    tick();
    #1;
    check("lock_m1_grant", 32'(grant), 32'b10);
    check("lock_m1_adr", s_adr, 32'h44);
    tick();
    idle_all();
    tick();
    tick();

    // Watchdog: slave never answers m0
    drive_m(0, 1'b1, 1'b0, 32'h30, 32'h0, 3'b000);
    for (int k = 1; k <= 8; k++) begin
      tick();
      #1;
      if (k < 8) begin
        check($sformatf("wd_noerr_c%0d", k), 32'({m0_err, s_stb}), 32'b01);
      end else begin
        check("wd_err", 32'(m0_err), 32'd1);
        check("wd_stb_forced_low", 32'(s_stb), 32'd0);
        check("wd_grant_kept", 32'(grant), 32'b01);
        check("wd_timeout_not_yet", 32'(timeout), 32'd0);
      end
    end
    tick();
    drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    #1;
    check("wd_timeout_pulse", 32'(timeout), 32'd1);
    check("wd_err_done", 32'(m0_err), 32'd0);
    tick();
    #1 check("wd_timeout_end", 32'(timeout), 32'd0);
    tick();

    // Watchdog: ack arrives in the firing cycle
    drive_m(0, 1'b1, 1'b0, 32'h34, 32'h0, 3'b000);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 8) begin s_ack = 1'b1; s_rdat = 32'h1234_5678; end
      #1;
      if (k == 8) begin
        check("wd_ack_wins_ack", 32'(m0_ack), 32'd1);
        check("wd_ack_wins_err", 32'(m0_err), 32'd0);
        check("wd_ack_wins_stb", 32'(s_stb), 32'd1);
      end
    end
    tick();
    idle_all();
    #1 check("wd_ack_no_timeout", 32'(timeout), 32'd0);
    tick();
    tick();

    // Async reset mid-transfer while m1 is granted
    drive_m(1, 1'b1, 1'b0, 32'h50, 32'h0, 3'b000);
    tick();
    #1 check("ar_g1", 32'({grant, s_stb}), 32'b101);
    #2 nrst = 1'b0;
    #1;
    check("ar_s_cyc_stb", 32'({s_cyc, s_stb}), 32'd0);
    check("ar_grant", 32'(grant), 32'd0);
    drive_m(0, 1'b1, 1'b0, 32'h60, 32'h0, 3'b000);
    tick();
    tick();
    nrst = 1'b1;
    #1 check("ar_release_idle", 32'(grant), 32'd0);
    tick();
    #1 check("ar_m0_first", 32'(grant), 32'b01);
    idle_all();
    tick();
    tick();

    // Randomized traffic from a clean reset
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
    mdl_last = 1;
    eng_init(40, 40, 3);
    engine(700, 3, 3);
    left[0] = 0; left[1] = 0;
    engine(30, 3, 3);
    check("drain_done", 32'({busy[0], busy[1]}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
